wishbone_master_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single Wishbone slave port of the

---
 rtl/wishbone_master_arbiter_if.sv | 33 +++
 rtl/wishbone_master_arbiter.sv | 116 +++++++++++
 tb/tb_wishbone_master_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_master_arbiter_if.sv
// Bus bundle joining N Wishbone masters, the round-robin arbiter and the bridge slave port.
// The master modport is the arbiter's view. The slave modport is the environment's view (the masters plus the bridge).
interface wishbone_master_arbiter_if #(
    parameter int p_num_masters = 2
);
    logic [p_num_masters-1:0]       m_cyc_i;
    logic [p_num_masters-1:0]       m_stb_i;
    logic [p_num_masters-1:0]       m_we_i;
    logic [p_num_masters-1:0][3:0]  m_sel_i;
    logic [p_num_masters-1:0][31:0] m_adr_i;
    logic [p_num_masters-1:0][31:0] m_dat_i;
    logic [p_num_masters-1:0]       m_ack_o;
    logic [p_num_masters-1:0][31:0] m_dat_o;

    logic        s_cyc_o;
    logic        s_stb_o;
    logic        s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;

    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        output m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );

    modport slave (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        input  m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );
endinterface

// File: rtl/wishbone_master_arbiter.sv
// Round-robin arbiter that gives the bridge slave port to one master per bus cycle. Grant lands 1 cycle after cyc and stays locked until the master drops cyc.
// The WISHBONE_ARB_TIMEOUT_EN define adds a forced ack when stb stalls. Without it, a stalled slave holds the grant forever.
module wishbone_master_arbiter #(
    parameter int p_num_masters    = 2,
    parameter int p_timeout_cycles = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    wishbone_master_arbiter_if.master bus,
    output logic [p_num_masters-1:0] o_grant,
    output logic                     o_timeout
);
    localparam int W = (p_num_masters > 1) ? $clog2(p_num_masters) : 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]               r_state;
    logic [p_num_masters-1:0] r_grant;
    logic [W-1:0]             r_gidx;
    logic [W-1:0]             r_last_idx;
    logic [W-1:0]             w_win_idx;
    logic                     w_any_req;
    logic                     w_busy;
    logic                     w_timeout;

    assign w_busy  = (r_state == ST_BUSY);
    assign o_grant = r_grant;

    // Search downward so the nearest requester after r_last_idx is written last and wins.
    always_comb begin
        w_any_req = 1'b0;
        w_win_idx = '0;
        for (int k = p_num_masters; k >= 1; k--) begin
            if (bus.m_cyc_i[(int'(r_last_idx) + k) % p_num_masters]) begin
                w_any_req = 1'b1;
                w_win_idx = W'((int'(r_last_idx) + k) % p_num_masters);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_gidx     <= '0;
            r_last_idx <= W'(p_num_masters - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ST_BUSY;
                        r_gidx  <= w_win_idx;
                        r_grant <= {{(p_num_masters-1){1'b0}}, 1'b1} << w_win_idx;
                    end
                end
                default: begin
                    if (!bus.m_cyc_i[r_gidx]) begin
                        r_state    <= ST_IDLE;
                        r_last_idx <= r_gidx;
                        r_grant    <= '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_sel_o = '0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        if (w_busy) begin
            bus.s_cyc_o = bus.m_cyc_i[r_gidx];
            bus.s_stb_o = bus.m_stb_i[r_gidx];
            bus.s_we_o  = bus.m_we_i[r_gidx];
            bus.s_sel_o = bus.m_sel_i[r_gidx];
            bus.s_adr_o = bus.m_adr_i[r_gidx];
            bus.s_dat_o = bus.m_dat_i[r_gidx];
        end
    end

    always_comb begin
        bus.m_ack_o = '0;
        bus.m_dat_o = '0;
        if (w_busy) begin
            bus.m_ack_o[r_gidx] = (bus.s_ack_i & bus.m_stb_i[r_gidx]) | w_timeout;
            bus.m_dat_o[r_gidx] = w_timeout ? 32'hDEAD_BEEF : bus.s_dat_i;
        end
    end

`ifdef WISHBONE_ARB_TIMEOUT_EN
    logic [7:0] r_to_cnt;

    // The forced ack fires on the p_timeout_cycles-th stalled beat, so it compares against the count minus one.
    assign w_timeout = w_busy & bus.m_stb_i[r_gidx] & ~bus.s_ack_i &
                       (r_to_cnt == 8'(p_timeout_cycles - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (!w_busy || bus.s_ack_i || w_timeout) begin
            r_to_cnt <= '0;
        end else if (bus.m_stb_i[r_gidx]) begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end
`else
    logic w_unused_to_cfg;
    assign w_unused_to_cfg = ^8'(p_timeout_cycles);
    assign w_timeout       = 1'b0;
`endif

    assign o_timeout = w_timeout;
endmodule

// File: tb/tb_wishbone_master_arbiter.sv
// Scoreboarded bench: per-cycle expectations from a queue-free rotation model, checked by a negedge monitor.
module tb_wishbone_master_arbiter;
    localparam int N  = 3;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] grant;
    logic         tmo;

    always #5 clk = ~clk;

    wishbone_master_arbiter_if #(.p_num_masters(N)) bus ();

    wishbone_master_arbiter #(
        .p_num_masters   (N),
        .p_timeout_cycles(TO)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .bus      (bus),
        .o_grant  (grant),
        .o_timeout(tmo)
    );

    typedef struct packed {
        logic [N-1:0]       grant;
        logic               s_cyc;
        logic               s_stb;
        logic               s_we;
        logic [3:0]         s_sel;
        logic [31:0]        s_adr;
        logic [31:0]        s_dat;
        logic [N-1:0]       ack;
        logic [N-1:0][31:0] mdat;
        logic               tmo;
    } snap_t;

    snap_t sbq[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc_no = 0;

    // Reference model: who owns the bus (-1 = free), who was served last, and the current stall run length.
    int owner = -1;
    int last  = N - 1;
    int stall = 0;

    int hold[N];
    bit rnd_phase = 1'b0;
    int waits[N];
    logic [N-1:0] prev_grant = '0;

    task automatic step();
        snap_t e;
        int    g;
        int    w;
        bit    to;
        e  = '0;
        to = 1'b0;
        if (!rst_n) begin
            owner = -1;
            last  = N - 1;
            stall = 0;
        end else if (owner < 0) begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && bus.m_cyc_i[(last + k) % N]) w = (last + k) % N;
            owner = w;
            stall = 0;
        end else begin
            g = owner;
            e.grant[g] = 1'b1;
            e.s_cyc = bus.m_cyc_i[g];
            e.s_stb = bus.m_stb_i[g];
            e.s_we  = bus.m_we_i[g];
            e.s_sel = bus.m_sel_i[g];
            e.s_adr = bus.m_adr_i[g];
            e.s_dat = bus.m_dat_i[g];
`ifdef WISHBONE_ARB_TIMEOUT_EN
            if (bus.s_ack_i) stall = 0;
            else if (bus.m_stb_i[g]) begin
                stall++;
                if (stall == TO) begin
                    to    = 1'b1;
                    stall = 0;
                end
            end
`endif
            e.ack[g]  = (bus.s_ack_i & bus.m_stb_i[g]) | to;
            e.mdat[g] = to ? 32'hDEAD_BEEF : bus.s_dat_i;
            e.tmo     = to;
            if (!bus.m_cyc_i[g]) begin
                last  = g;
                owner = -1;
                stall = 0;
            end
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        bus.m_cyc_i[i] = c;
        bus.m_stb_i[i] = s;
        bus.m_we_i[i]  = w;
        bus.m_sel_i[i] = 4'hF;
        bus.m_adr_i[i] = a;
        bus.m_dat_i[i] = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) set_m(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Monitor: pops one expectation per cycle and checks a fairness bound on every new grant.
    always @(negedge clk) begin
        snap_t a;
        snap_t e;
        snap_t a2;
        snap_t e2;
        int    g;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a.grant = grant;
            a.s_cyc = bus.s_cyc_o;
            a.s_stb = bus.s_stb_o;
            a.s_we  = bus.s_we_o;
            a.s_sel = bus.s_sel_o;
            a.s_adr = bus.s_adr_o;
            a.s_dat = bus.s_dat_o;
            a.ack   = bus.m_ack_o;
            a.mdat  = bus.m_dat_o;
            a.tmo   = tmo;
            tests++;
            if (a.grant !== e.grant) begin
                fails++;
                $display("FAIL grant cycle=%0d got=%b expected=%b", cyc_no, a.grant, e.grant);
            end
            a2 = a;
            a2.grant = '0;
            e2 = e;
            e2.grant = '0;
            tests++;
            if (a2 !== e2) begin
                fails++;
                $display("FAIL bus cycle=%0d got=%h expected=%h", cyc_no, a2, e2);
            end
        end
        if (rnd_phase) begin
            for (int i = 0; i < N; i++) if (!bus.m_cyc_i[i]) waits[i] = 0;
            if (grant != '0 && prev_grant == '0) begin
                g = 0;
                for (int i = 0; i < N; i++) if (grant[i]) g = i;
                for (int i = 0; i < N; i++) if (i != g && bus.m_cyc_i[i]) waits[i]++;
                tests++;
                if (waits[g] > N - 1) begin
                    fails++;
                    $display("FAIL wait master=%0d got=%0d max=%0d", g, waits[g], N - 1);
                end
                waits[g] = 0;
            end
        end
        prev_grant = grant;
        cyc_no++;
    end

    initial begin
        rst_n = 1'b0;
        clear_all();
        bus.s_ack_i = 1'b0;
        bus.s_dat_i = '0;
        for (int i = 0; i < N; i++) begin
            hold[i]  = 0;
            waits[i] = 0;
        end
        @(posedge clk);
        #1;
        step();
        rst_n = 1'b1;
        step();

        // m0 single read, slave acks with data 1
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'h0);
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 32'h1;
        step();
        step();
        clear_all();
        step();
        step();

        // m0 and m1 together, two cycles each, both re-request: rotation
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h3000_0010, 32'h0);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h3000_0020, 32'h0);
        bus.s_dat_i = 32'h1234_5678;
        step();
        step();
        step();
        bus.m_cyc_i[0] = 1'b0;
        bus.m_stb_i[0] = 1'b0;
        step();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h3000_0010, 32'h0);
        step();
        step();
        step();
        bus.m_cyc_i[1] = 1'b0;
        bus.m_stb_i[1] = 1'b0;
        step();
        step();
        step();
        clear_all();
        step();
        step();

        // m1 write while m0 idle
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h3000_0004, 32'hCAFE_0001);
        step();
        step();
        step();
        clear_all();
        step();
        step();

        // reset mid-BUSY with m0 granted; afterwards m0 must beat m2
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h3000_0008, 32'h0);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_m(2, 1'b1, 1'b1, 1'b0, 32'h3000_000C, 32'h0);
        step();
        step();
        clear_all();
        step();
        step();
        step();
        step();

        // stalled slave: forced ack when the timeout feature is built in, otherwise the grant is held
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'h0);
        bus.s_ack_i = 1'b0;
        for (int i = 0; i < 7; i++) step();
        clear_all();
        step();
        step();

        // random traffic
        for (int i = 0; i < N; i++) hold[i] = 0;
        rnd_phase = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (owner == i) begin
                    if (hold[i] > 0) begin
                        hold[i]--;
                        bus.m_stb_i[i] = 1'($urandom_range(0, 1));
                    end else begin
                        bus.m_cyc_i[i] = 1'b0;
                        bus.m_stb_i[i] = 1'b0;
                    end
                end else if (!bus.m_cyc_i[i] && $urandom_range(0, 2) == 0) begin
                    bus.m_cyc_i[i] = 1'b1;
                    bus.m_stb_i[i] = 1'b1;
                    bus.m_we_i[i]  = 1'($urandom_range(0, 1));
                    bus.m_sel_i[i] = 4'($urandom);
                    bus.m_adr_i[i] = $urandom;
                    bus.m_dat_i[i] = $urandom;
                    hold[i] = $urandom_range(1, 4);
                end
            end
            bus.s_ack_i = 1'($urandom_range(0, 1));
            bus.s_dat_i = $urandom;
            step();
        end
        rnd_phase = 1'b0;
        clear_all();
        step();
        step();
        step();
        #10;
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d entries left expected=0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
